// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions between the issue decoder and the datapath ALU:
//   - alu_op_e      : 4-bit ALU op code
//   - OPC_* / FN_*  : MIPS opcode and R-type funct constants
//   - alu_cmd_t     : decoded command {op, nA, nB, wb_reg, illegal}
//   - skid_state_e  : occupancy state of the output skid buffer
//   - alu_decode()  : pure decode of one instruction + register values
// ALU_N is the datapath width (minimum 16); the decoder's N must equal it.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned ALU_N = 32;

   typedef enum logic [3:0] {
      ALU_SHL  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SHRL = 4'b0011,
      ALU_SHRA = 4'b0100,
      ALU_AND  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_OR   = 4'b0111,
      ALU_XOR  = 4'b1000
   } alu_op_e;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;

   typedef struct packed {
      logic [3:0]       op;
      logic [ALU_N-1:0] nA;
      logic [ALU_N-1:0] nB;
      logic [4:0]       wb_reg;
      logic             illegal;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   // Anything not matched leaves the all-zero command and raises illegal.
   function automatic alu_cmd_t alu_decode(input logic [31:0]      instr,
                                           input logic [ALU_N-1:0] rs,
                                           input logic [ALU_N-1:0] rt);
      alu_cmd_t         c;
      logic [ALU_N-1:0] sext;
      logic [ALU_N-1:0] zext;
      logic [ALU_N-1:0] shamt;
      logic [ALU_N-1:0] rs_sh;
      sext  = {{(ALU_N-16){instr[15]}}, instr[15:0]};
      zext  = {{(ALU_N-16){1'b0}}, instr[15:0]};
      shamt = {{(ALU_N-5){1'b0}}, instr[10:6]};
      rs_sh = {{(ALU_N-5){1'b0}}, rs[4:0]};
      c     = '0;
      case (instr[31:26])
         OPC_RTYPE: begin
            c.wb_reg = instr[15:11];
            c.nA     = rs;
            c.nB     = rt;
            case (instr[5:0])
               FN_ADD, FN_ADDU: c.op = ALU_ADD;
               FN_SUB, FN_SUBU: c.op = ALU_SUB;
               FN_AND:          c.op = ALU_AND;
               FN_OR:           c.op = ALU_OR;
               FN_XOR:          c.op = ALU_XOR;
               FN_SLL:  begin c.op = ALU_SHL;  c.nA = rt; c.nB = shamt; end
               FN_SRL:  begin c.op = ALU_SHRL; c.nA = rt; c.nB = shamt; end
               FN_SRA:  begin c.op = ALU_SHRA; c.nA = rt; c.nB = shamt; end
               FN_SLLV: begin c.op = ALU_SHL;  c.nA = rt; c.nB = rs_sh; end
               FN_SRLV: begin c.op = ALU_SHRL; c.nA = rt; c.nB = rs_sh; end
               FN_SRAV: begin c.op = ALU_SHRA; c.nA = rt; c.nB = rs_sh; end
               default: c = '{op: 4'b0000, nA: '0, nB: '0, wb_reg: 5'd0, illegal: 1'b1};
            endcase
         end
         OPC_ADDI, OPC_ADDIU, OPC_LW: begin
            c.op = ALU_ADD; c.nA = rs; c.nB = sext; c.wb_reg = instr[20:16];
         end
         OPC_SW: begin
            c.op = ALU_ADD; c.nA = rs; c.nB = sext;
         end
         OPC_ANDI: begin
            c.op = ALU_AND; c.nA = rs; c.nB = zext; c.wb_reg = instr[20:16];
         end
         OPC_ORI: begin
            c.op = ALU_OR; c.nA = rs; c.nB = zext; c.wb_reg = instr[20:16];
         end
         OPC_XORI: begin
            c.op = ALU_XOR; c.nA = rs; c.nB = zext; c.wb_reg = instr[20:16];
         end
         OPC_LUI: begin
            c.op = ALU_SHL; c.nA = zext; c.nB = ALU_N'(16); c.wb_reg = instr[20:16];
         end
         // Branch compare: the ALU Z flag of rs - rt is the outcome.
         OPC_BEQ, OPC_BNE: begin
            c.op = ALU_SUB; c.nA = rs; c.nB = rt;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// -----------------------------------------------------------------------------
// alu_skid_buffer
// Two-entry registered pipeline stage (output register + skid register).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid_i      : upstream payload present
//   in_ready_o      : stage can accept (straight from a flop)
//   data_i [W]      : upstream payload
//   out_valid_o     : payload presented downstream
//   out_ready_i     : downstream accepts
//   data_o [W]      : presented payload (held stable while stalled)
// Handshake: a beat moves on a rising edge where valid && ready; valid never
// depends on ready, and once out_valid_o is high data_o holds until taken.
// -----------------------------------------------------------------------------
module alu_skid_buffer
   import alu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] data_o
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] out_q, out_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_ready_q;
   logic         in_fire;
   logic         out_fire;

   assign in_fire  = in_valid_i && in_ready_q;
   assign out_fire = (state_q != SKID_EMPTY) && out_ready_i;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (in_fire) begin
               out_d   = data_i;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (in_fire && out_fire) begin
               out_d = data_i;
            end else if (in_fire) begin
               skid_d  = data_i;
               state_d = SKID_FULL;
            end else if (out_fire) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            // in_ready is low here, so only the drain can happen.
            if (out_fire) begin
               out_d   = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SKID_EMPTY;
         out_q      <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != SKID_FULL);
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (state_q != SKID_EMPTY);
   assign data_o      = out_q;

endmodule

// File: rtl/alu_issue_decoder.sv
// -----------------------------------------------------------------------------
// alu_issue_decoder
// Decodes one MIPS instruction (plus its rs/rt register values) per input
// handshake into an ALU command, presented one cycle later from a 2-entry
// skid buffer so ALU stalls never form a combinational ready path upstream.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid, in_ready         : input handshake (in_ready is a flop)
//   instr, rs_data, rt_data    : instruction word and register-file values
//   out_valid, out_ready       : output handshake
//   op, nA, nB, wb_reg, illegal: decoded ALU command
// N must equal alu_pkg::ALU_N.
// -----------------------------------------------------------------------------
module alu_issue_decoder
   import alu_pkg::*;
#(
   parameter int unsigned N = ALU_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  instr,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] rt_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   op,
   output logic [N-1:0] nA,
   output logic [N-1:0] nB,
   output logic [4:0]   wb_reg,
   output logic         illegal
);

   alu_cmd_t dec_cmd;
   alu_cmd_t out_cmd;

   always_comb begin
      dec_cmd = alu_decode(instr, rs_data, rt_data);
   end

   alu_skid_buffer #(
      .W($bits(alu_cmd_t))
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .data_i     (dec_cmd),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .data_o     (out_cmd)
   );

   assign op      = out_cmd.op;
   assign nA      = out_cmd.nA;
   assign nB      = out_cmd.nB;
   assign wb_reg  = out_cmd.wb_reg;
   assign illegal = out_cmd.illegal;

endmodule

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
- Front end feeding the N-bit datapath ALU: accepts one MIPS instruction word plus its two register-file read values per handshake.
- Decodes each instruction into the 4-bit ALU op code, the two ALU operands, a write-back register index and an illegal flag.
- Output is registered and sits behind a 2-entry skid buffer, so the ALU side can stall without creating a combinational ready path back to fetch/regfile.

Parameters:
- N, 32, datapath/operand width in bits (minimum 16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents instr/rs_data/rt_data.
- in_ready  out  1  decoder can accept; driven directly from a flop.
- instr  in  32  MIPS instruction word.
- rs_data  in  N  register-file value for instr[25:21].
- rt_data  in  N  register-file value for instr[20:16].
- out_valid  out  1  decoded command is presented.
- out_ready  in  1  ALU side accepts.
- op  out  4  ALU op code.
- nA  out  N  ALU operand A.
- nB  out  N  ALU operand B.
- wb_reg  out  5  destination register index; 0 means no write-back.
- illegal  out  1  instruction not in the decode table.

Behaviour:
- Reset, asynchronous on rst_n low: out_valid=0, in_ready=1, op=0, nA=0, nB=0, wb_reg=0, illegal=0. Both buffer entries are emptied.
- Reset mid-transfer drops any held command; no handshake completes in the cycle reset is asserted.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle: a command accepted at edge k is visible on the outputs after edge k, when the buffer was empty or draining.
- Skid buffer, states EMPTY / ONE / FULL:
  - EMPTY: an input transfer loads the output register -> ONE.
  - ONE with input transfer and no output transfer: the new command goes to the skid register, output unchanged -> FULL, in_ready=0.
  - ONE with input transfer and output transfer: the output register is reloaded -> stays ONE.
  - ONE with output transfer only -> EMPTY.
  - FULL with output transfer: the skid register moves into the output register -> ONE, in_ready=1 next cycle.
  - Order is strict FIFO. The outputs are stable while out_valid && !out_ready.
- Decode table. Immediates: sext = sign-extended instr[15:0], zext = zero-extended instr[15:0], shamt = instr[10:6] zero-extended.

  R-type, opcode 0:
  - funct 0x20/0x21: add (0010), nA=rs, nB=rt, wb=rd.
  - funct 0x22/0x23: sub (0110), nA=rs, nB=rt, wb=rd.
  - funct 0x24: And (0101), operands and wb as add.
  - funct 0x25: Or (0111), operands and wb as add.
  - funct 0x26: Xor (1000), operands and wb as add.
  - funct 0x00: shL (0001), nA=rt, nB=shamt, wb=rd.
  - funct 0x02: shRl (0011), nA=rt, nB=shamt, wb=rd.
  - funct 0x03: shRa (0100), nA=rt, nB=shamt, wb=rd.
  - funct 0x04: shL, nA=rt, nB=zero-extended rs[4:0], wb=rd.
  - funct 0x06: shRl, same operands as funct 0x04.
  - funct 0x07: shRa, same operands as funct 0x04.

  I-type:
  - opcode 0x08/0x09 addi/addiu: add, nA=rs, nB=sext, wb=rt.
  - 0x0C andi: And, nA=rs, nB=zext, wb=rt.
  - 0x0D ori: Or, nA=rs, nB=zext, wb=rt.
  - 0x0E xori: Xor, nA=rs, nB=zext, wb=rt.
  - 0x0F lui: shL, nA=zext, nB=16, wb=rt.
  - 0x23 lw: add, nA=rs, nB=sext, wb=rt.
  - 0x2B sw: add, nA=rs, nB=sext, wb=0.
  - 0x04 beq / 0x05 bne: sub, nA=rs, nB=rt, wb=0. The ALU Z flag is the compare result.

- Any other opcode/funct: op=0000, nA=0, nB=0, wb=0, illegal=1. It still transfers normally and is never silently dropped.
- When the destination field is 0, wb_reg is 0. No special masking is applied.
- Width rules: sign/zero extension is to N bits. Shift amounts occupy the low 5 bits of nB and the upper bits are 0.

Decomposition:
- Shared package alu_pkg holds:
  - the op enum: add=0010, sub=0110, shL=0001, shRl=0011, shRa=0100, And=0101, Or=0111, Xor=1000. The ALU is refactored to import it.
  - opcode constants and funct constants.
  - a packed struct alu_cmd_t {op, nA, nB, wb_reg, illegal}.
- The decode is a pure function in the package, instantiated once.
- One sub-module, alu_skid_buffer, parameterised by payload width, carries alu_cmd_t.

Test Plan:
- Reset with in_valid=1 held: all outputs 0 and in_ready=1 during reset; the first edge after release accepts the command.
- add $3,$1,$2 (0x00221820) with rs=5, rt=7 -> next cycle op=0010, nA=5, nB=7, wb_reg=3, illegal=0.
- sra $4,$2,3 (0x000220C3) with rt=0x80000000 -> op=0100, nA=0x80000000, nB=3, wb_reg=4. Then lui $5,0x1234 (0x3C051234) -> op=0001, nA=0x1234, nB=16, wb_reg=5.
- Backpressure: out_ready=0 and three back-to-back sends of addi imm 1, 2, 3. Two are accepted, then in_ready=0. Raising out_ready outputs nB=1, 2, 3 in order with no loss or duplication.
- Simultaneous in/out transfer every cycle for 100 random legal instructions: in_ready stays 1 and throughput is 1 per cycle, matching a reference decode model.
- Illegal opcode 0x3F: op=0, illegal=1, wb_reg=0, transferred once. Then assert rst_n=0 while in FULL: out_valid falls immediately and both entries are discarded.
